// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Purpose  : Decode-to-execute pipeline register placed right after the
//            32x64 register file (X31 reads as zero). Captures decode control
//            and regfile read data and replaces stale operands with in-flight
//            EX/MEM or MEM/WB results. It also detects load-use hazards,
//            inserts a single bubble, and counts those bubbles.
// Ports    : clk, reset (sync, active-high)
//            hold, flush            - freeze / squash controls
//            id_*                   - decode slot: valid, Rn/Rm/Rd, source
//                                     usage, RegWrite/MemRead, read data A/B
//            exm_*, wb_*            - forwarding sources (EX/MEM, MEM/WB)
//            ex_*                   - registered execute-slot outputs
//            stall_req              - combinational hold request to fetch/decode
//            bubble_cnt             - saturating count of load-use bubbles
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_Rn,
  input  logic [4:0]       id_Rm,
  input  logic [4:0]       id_Rd,
  input  logic             id_useRn,
  input  logic             id_useRm,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic [WIDTH-1:0] id_A,
  input  logic [WIDTH-1:0] id_B,
  input  logic             exm_RegWrite,
  input  logic [4:0]       exm_Rd,
  input  logic [WIDTH-1:0] exm_Result,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_Rd,
  input  logic [WIDTH-1:0] wb_Result,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_A,
  output logic [WIDTH-1:0] ex_B,
  output logic [4:0]       ex_Rd,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             stall_req,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [4:0] XZR = 5'd31;

  logic             exm_fwd_a;
  logic             exm_fwd_b;
  logic             wb_fwd_a;
  logic             wb_fwd_b;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic             hazard;

  // A producer writing XZR never forwards; its write is architecturally lost.
  assign exm_fwd_a = exm_RegWrite && (exm_Rd == id_Rn) && (exm_Rd != XZR);
  assign exm_fwd_b = exm_RegWrite && (exm_Rd == id_Rm) && (exm_Rd != XZR);
  // The MEM/WB path also covers the regfile write landing on this same edge,
  // whose value the regfile read port has not yet picked up.
  assign wb_fwd_a  = wb_RegWrite && (wb_Rd == id_Rn) && (wb_Rd != XZR);
  assign wb_fwd_b  = wb_RegWrite && (wb_Rd == id_Rm) && (wb_Rd != XZR);

  // The younger EX/MEM result wins over MEM/WB.
  always_comb begin
    fwd_a = id_A;
    if (id_Rn == XZR)   fwd_a = '0;
    else if (exm_fwd_a) fwd_a = exm_Result;
    else if (wb_fwd_a)  fwd_a = wb_Result;
  end

  always_comb begin
    fwd_b = id_B;
    if (id_Rm == XZR)   fwd_b = '0;
    else if (exm_fwd_b) fwd_b = exm_Result;
    else if (wb_fwd_b)  fwd_b = wb_Result;
  end

  // A load in EX cannot supply its data until it reaches EX/MEM, so a
  // consumer in decode must wait exactly one cycle.
  assign hazard = ex_valid && ex_MemRead && ex_RegWrite && (ex_Rd != XZR) &&
                  id_valid &&
                  ((id_useRn && (id_Rn == ex_Rd)) ||
                   (id_useRm && (id_Rm == ex_Rd)));

  // hold and flush already dominate the stage, so a stall would be redundant.
  assign stall_req = hazard && !hold && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_A        <= '0;
      ex_B        <= '0;
      ex_Rd       <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      bubble_cnt  <= '0;
    end else if (flush) begin
      // Bubble: control cleared, data fields kept as they were.
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
    end else if (hold) begin
      // Everything keeps its value.
    end else if (stall_req) begin
      ex_valid    <= 1'b0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      if (bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end else begin
      ex_valid    <= id_valid;
      ex_A        <= fwd_a;
      ex_B        <= fwd_b;
      ex_Rd       <= id_Rd;
      ex_RegWrite <= id_RegWrite && id_valid;
      ex_MemRead  <= id_MemRead && id_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Purpose  : Directed-vector bench for id_ex_operand_stage (CNT_W = 2 so the
//            counter saturation is reachable). The stimulus process pushes the
//            hand-computed response for each cycle into a queue; a separate
//            monitor pops it, samples stall_req before the edge and the ex_*
//            outputs after it, and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

  localparam int WIDTH = 64;
  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [4:0]       id_Rn;
  logic [4:0]       id_Rm;
  logic [4:0]       id_Rd;
  logic             id_useRn;
  logic             id_useRm;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic [WIDTH-1:0] id_A;
  logic [WIDTH-1:0] id_B;
  logic             exm_RegWrite;
  logic [4:0]       exm_Rd;
  logic [WIDTH-1:0] exm_Result;
  logic             wb_RegWrite;
  logic [4:0]       wb_Rd;
  logic [WIDTH-1:0] wb_Result;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_A;
  logic [WIDTH-1:0] ex_B;
  logic [4:0]       ex_Rd;
  logic             ex_RegWrite;
  logic             ex_MemRead;
  logic             stall_req;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_operand_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
    .id_useRn(id_useRn), .id_useRm(id_useRm),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
    .id_A(id_A), .id_B(id_B),
    .exm_RegWrite(exm_RegWrite), .exm_Rd(exm_Rd), .exm_Result(exm_Result),
    .wb_RegWrite(wb_RegWrite), .wb_Rd(wb_Rd), .wb_Result(wb_Result),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_Rd(ex_Rd),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .stall_req(stall_req), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          chk_dat;  // compare ex_A/ex_B/ex_Rd as well
    logic        st;
    logic        v;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic [1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input int tag, input string f, input logic [63:0] act,
                     input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL vec%0d %s: got %h expected %h", tag, f, act, expv);
    end
  endtask

  // Monitor: stall_req is sampled 1 ns before the edge using the inputs of
  // the current cycle; the registered outputs 1 ns after it.
  initial begin
    exp_t e;
    logic st_s;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        e    = sb.pop_front();
        st_s = stall_req;
        @(posedge clk);
        #1;
        cmp(e.tag, "stall_req",   {63'd0, st_s},        {63'd0, e.st});
        cmp(e.tag, "ex_valid",    {63'd0, ex_valid},    {63'd0, e.v});
        cmp(e.tag, "ex_RegWrite", {63'd0, ex_RegWrite}, {63'd0, e.rw});
        cmp(e.tag, "ex_MemRead",  {63'd0, ex_MemRead},  {63'd0, e.mr});
        cmp(e.tag, "bubble_cnt",  {62'd0, bubble_cnt},  {62'd0, e.cnt});
        if (e.chk_dat) begin
          cmp(e.tag, "ex_A",  ex_A, e.a);
          cmp(e.tag, "ex_B",  ex_B, e.b);
          cmp(e.tag, "ex_Rd", {59'd0, ex_Rd}, {59'd0, e.rd});
        end
      end
    end
  end

  task automatic expect_out(input int tag, input logic st, input bit chk_dat,
                            input logic v, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] rd,
                            input logic rw, input logic mr,
                            input logic [1:0] cnt);
    exp_t e;
    e.tag = tag; e.chk_dat = chk_dat; e.st = st; e.v = v; e.a = a; e.b = b;
    e.rd = rd; e.rw = rw; e.mr = mr; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic idle();
    reset = 1'b0; hold = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_Rn = 5'd0; id_Rm = 5'd0; id_Rd = 5'd0;
    id_useRn = 1'b0; id_useRm = 1'b0; id_RegWrite = 1'b0; id_MemRead = 1'b0;
    id_A = '0; id_B = '0;
    exm_RegWrite = 1'b0; exm_Rd = 5'd0; exm_Result = '0;
    wb_RegWrite = 1'b0; wb_Rd = 5'd0; wb_Result = '0;
  endtask

  task automatic rnd();
    hold = 1'($urandom); flush = 1'($urandom);
    id_valid = 1'($urandom); id_Rn = 5'($urandom); id_Rm = 5'($urandom);
    id_Rd = 5'($urandom); id_useRn = 1'($urandom); id_useRm = 1'($urandom);
    id_RegWrite = 1'($urandom); id_MemRead = 1'($urandom);
    id_A = {$urandom, $urandom}; id_B = {$urandom, $urandom};
    exm_RegWrite = 1'($urandom); exm_Rd = 5'($urandom);
    exm_Result = {$urandom, $urandom};
    wb_RegWrite = 1'($urandom); wb_Rd = 5'($urandom);
    wb_Result = {$urandom, $urandom};
  endtask

  task automatic dec(input logic v, input logic [4:0] rn, input logic [63:0] a,
                     input logic urn, input logic [4:0] rm,
                     input logic [63:0] b, input logic urm,
                     input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_Rn = rn; id_A = a; id_useRn = urn;
    id_Rm = rm; id_B = b; id_useRm = urm;
    id_Rd = rd; id_RegWrite = rw; id_MemRead = mr;
  endtask

  // LDUR X12, [X12]: a load whose base is the previous load's destination.
  task automatic ld12();
    dec(1, 12, 64'h12, 1, 31, 64'h0, 0, 12, 1, 1);
  endtask

  initial begin
    logic [1:0] sat;
    idle();
    rnd();
    reset = 1'b1;

    // Reset with random inputs, two cycles.
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); rnd(); reset = 1'b1;
      expect_out(i, 0, 1, 0, 64'h0, 64'h0, 0, 0, 0, 2'd0);
    end

    // Plain capture.
    @(negedge clk); idle();
    dec(1, 3, 64'h11, 1, 4, 64'h22, 1, 7, 1, 0);
    expect_out(3, 0, 1, 1, 64'h11, 64'h22, 7, 1, 0, 2'd0);

    // EX/MEM beats MEM/WB.
    @(negedge clk); idle();
    dec(1, 3, 64'h11, 1, 4, 64'h22, 1, 8, 1, 0);
    exm_RegWrite = 1; exm_Rd = 3; exm_Result = 64'hAA;
    wb_RegWrite = 1; wb_Rd = 3; wb_Result = 64'hBB;
    expect_out(4, 0, 1, 1, 64'hAA, 64'h22, 8, 1, 0, 2'd0);

    // EX/MEM not writing: MEM/WB supplies.
    @(negedge clk);
    exm_RegWrite = 0;
    expect_out(5, 0, 1, 1, 64'hBB, 64'h22, 8, 1, 0, 2'd0);

    // XZR source reads zero even with a matching producer.
    @(negedge clk);
    id_Rn = 31; exm_RegWrite = 1; exm_Rd = 31;
    expect_out(6, 0, 1, 1, 64'h0, 64'h22, 8, 1, 0, 2'd0);

    // B from MEM/WB; EX/MEM writing XZR does not disturb A.
    @(negedge clk); idle();
    dec(1, 3, 64'h11, 1, 4, 64'h22, 1, 8, 1, 0);
    exm_RegWrite = 1; exm_Rd = 31; exm_Result = 64'hDD;
    wb_RegWrite = 1; wb_Rd = 4; wb_Result = 64'hCC;
    expect_out(7, 0, 1, 1, 64'h11, 64'hCC, 8, 1, 0, 2'd0);

    // LDUR X5 enters EX.
    @(negedge clk); idle();
    dec(1, 2, 64'h100, 1, 31, 64'h77, 0, 5, 1, 1);
    expect_out(8, 0, 1, 1, 64'h100, 64'h0, 5, 1, 1, 2'd0);

    // ADD X6, X1, X5 -> load-use stall, one bubble.
    @(negedge clk); idle();
    dec(1, 1, 64'h7, 1, 5, 64'h55, 1, 6, 1, 0);
    expect_out(9, 1, 0, 0, 64'h0, 64'h0, 0, 0, 0, 2'd1);

    // Re-presented ADD picks up the load result from EX/MEM.
    @(negedge clk);
    exm_RegWrite = 1; exm_Rd = 5; exm_Result = 64'h1234;
    expect_out(10, 0, 1, 1, 64'h7, 64'h1234, 6, 1, 0, 2'd1);

    // Load X9, then a consumer with flush: bubble, no stall, count unchanged.
    @(negedge clk); idle();
    dec(1, 2, 64'h200, 1, 31, 64'h77, 0, 9, 1, 1);
    expect_out(11, 0, 1, 1, 64'h200, 64'h0, 9, 1, 1, 2'd1);
    @(negedge clk); idle();
    dec(1, 9, 64'h3, 1, 4, 64'h4, 1, 14, 1, 0);
    flush = 1;
    expect_out(12, 0, 1, 0, 64'h200, 64'h0, 9, 0, 0, 2'd1);

    // Load X10, then 3 cycles of hold over a dependent consumer.
    @(negedge clk); idle();
    dec(1, 3, 64'h33, 1, 4, 64'h44, 1, 10, 1, 1);
    expect_out(13, 0, 1, 1, 64'h33, 64'h44, 10, 1, 1, 2'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle();
      dec(1, 10, 64'h99, 1, 4, 64'h98, 0, 11, 1, 0);
      hold = 1;
      expect_out(14 + i, 0, 1, 1, 64'h33, 64'h44, 10, 1, 1, 2'd1);
    end
    // Hold released: the hazard now stalls; data fields keep their values.
    @(negedge clk);
    hold = 0;
    expect_out(17, 1, 1, 0, 64'h33, 64'h44, 10, 0, 0, 2'd2);

    // Invalid decode slot behind a load: no stall, control masked.
    @(negedge clk); idle();
    dec(1, 0, 64'h5, 1, 0, 64'h0, 1, 12, 1, 1);
    expect_out(18, 0, 1, 1, 64'h5, 64'h0, 12, 1, 1, 2'd2);
    @(negedge clk); idle();
    dec(0, 12, 64'h66, 1, 12, 64'h67, 1, 13, 1, 1);
    expect_out(19, 0, 1, 0, 64'h66, 64'h67, 13, 0, 0, 2'd2);

    // Reset during a stall: bubble dropped, counter cleared.
    @(negedge clk); idle();
    dec(1, 0, 64'h5, 1, 0, 64'h0, 1, 12, 1, 1);
    expect_out(20, 0, 1, 1, 64'h5, 64'h0, 12, 1, 1, 2'd2);
    @(negedge clk); idle();
    ld12(); reset = 1;
    expect_out(21, 1, 1, 0, 64'h0, 64'h0, 0, 0, 0, 2'd0);
    @(negedge clk); idle();
    ld12();
    expect_out(22, 0, 1, 1, 64'h12, 64'h0, 12, 1, 1, 2'd0);

    // Saturation: five bubbles -> 1, 2, 3, 3, 3.
    for (int k = 1; k <= 5; k++) begin
      sat = (k > 3) ? 2'd3 : 2'(k);
      @(negedge clk); idle(); ld12();
      expect_out(22 + 2 * k - 1, 1, 0, 0, 64'h0, 64'h0, 0, 0, 0, sat);
      @(negedge clk); idle(); ld12();
      expect_out(22 + 2 * k, 0, 1, 1, 64'h12, 64'h0, 12, 1, 1, sat);
    end

    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly downstream of the 32x64 register file (X31 = XZR).
- Captures the regfile read data and decode control each cycle.
- Forwards in-flight results from EX/MEM and MEM/WB over stale regfile data.
- Detects load-use hazards, inserts one bubble, and drives a stall request back to fetch/decode. Counts inserted bubbles for debug.

Parameters:
WIDTH, 64, data width of operands and forwarded results
CNT_W, 32, width of the saturating bubble counter

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clk
hold  in  1  external freeze; stage keeps its contents
flush  in  1  branch squash; stage loads a bubble
id_valid  in  1  decode slot holds a real instruction
id_Rn, id_Rm, id_Rd  in  5 each  register numbers; id_Rn/id_Rm are the regfile ReadRegister1/2
id_useRn, id_useRm  in  1 each  the instruction actually consumes that source
id_RegWrite, id_MemRead  in  1 each  decode control bits
id_A, id_B  in  WIDTH each  regfile ReadData1/ReadData2
exm_RegWrite  in  1  EX/MEM producer writes a register
exm_Rd  in  5  EX/MEM destination register
exm_Result  in  WIDTH  EX/MEM result
wb_RegWrite  in  1  MEM/WB producer writes a register
wb_Rd  in  5  MEM/WB destination register
wb_Result  in  WIDTH  MEM/WB result; also the regfile WriteData this cycle
ex_valid  out  1  execute slot holds a real instruction
ex_A, ex_B  out  WIDTH each  captured, forwarded operands
ex_Rd  out  5  captured destination register
ex_RegWrite, ex_MemRead  out  1 each  captured control bits
stall_req  out  1  combinational; fetch/decode must hold this cycle
bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset: every registered output is 0, including ex_valid, ex_A, ex_B, ex_Rd, the control bits and bubble_cnt. Reset takes priority over all other inputs.
- Latency: 1 cycle from the decode inputs to the ex_* outputs.
- Forwarding mux, one per operand, evaluated at capture time (shown for A; B is identical using id_Rm/id_B):
  - id_Rn==31 -> 0.
  - else if exm_RegWrite and exm_Rd==id_Rn and exm_Rd!=31 -> exm_Result.
  - else if wb_RegWrite and wb_Rd==id_Rn and wb_Rd!=31 -> wb_Result.
  - else -> id_A.
  - EX/MEM has priority over MEM/WB.
  - The MEM/WB path covers the regfile write that lands on the same edge.
- Load-use hazard, combinational:
  - stall_req = ex_valid & ex_MemRead & ex_RegWrite & ex_Rd!=31 & id_valid & ((id_useRn & id_Rn==ex_Rd) | (id_useRm & id_Rm==ex_Rd)).
  - stall_req is forced to 0 while hold or flush is high.
- Next-state priority per rising edge:
  1. reset: clear everything.
  2. flush: load a bubble (ex_valid=0, ex_RegWrite=0, ex_MemRead=0; data fields are don't-care but held). The decode slot is discarded.
  3. hold: all registers keep their value and bubble_cnt does not change.
  4. stall_req: load a bubble and increment bubble_cnt. Decode is held upstream, so the next cycle re-presents the same instruction, which then forwards from EX/MEM.
  5. normal: capture the decode inputs and forwarded operands. ex_valid = id_valid. ex_RegWrite and ex_MemRead are masked by id_valid.
- bubble_cnt saturates at all-ones; it never wraps.
- An invalid decode slot (id_valid=0) never raises stall_req and never increments bubble_cnt.
- Reset asserted mid-stall: the bubble is dropped, stall_req falls the next cycle because ex_valid becomes 0, and bubble_cnt goes to 0.
- A load-use bubble inserts only one cycle. After it, the consumer sees the load result via the EX/MEM path.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs -> all outputs 0, stall_req=0, bubble_cnt=0.
- Plain capture: id_Rn=3, id_A=0x11, id_Rm=4, id_B=0x22, no forwarding -> next cycle ex_A=0x11, ex_B=0x22, ex_valid=1.
- Forward priority:
  - exm_Rd=3, exm_Result=0xAA and wb_Rd=3, wb_Result=0xBB, both RegWrite=1, id_Rn=3 -> ex_A=0xAA.
  - Same setup with exm_RegWrite=0 -> ex_A=0xBB.
  - Same setup with id_Rn=31 and exm_Rd=31 -> ex_A=0.
- Load-use: LDUR X5 in EX (ex_MemRead=1, ex_Rd=5), decode ADD using Rm=5 -> stall_req=1 for one cycle, ex_valid=0 next edge, bubble_cnt=1. On the following cycle stall_req=0, and with exm_Rd=5, exm_Result=0x1234 the result is ex_B=0x1234.
- Priority:
  - During a load-use stall, assert flush -> stall_req=0, bubble loaded, bubble_cnt unchanged.
  - Assert hold for 3 cycles -> ex_* are frozen and bubble_cnt is unchanged.
- Saturation: with CNT_W=2, trigger 5 load-use bubbles -> bubble_cnt sequence is 1, 2, 3, 3, 3.
